// File: rtl/attack_pkg.sv
// Shared types and constants for the attack scheduler: attack kinds, phase encodings,
// default phase durations and the phase-timer width.
package attack_pkg;

  localparam int TIMER_W = 25;

  localparam logic [TIMER_W-1:0] DEF_WINDUP_CYC  = 25'd4194304;
  localparam logic [TIMER_W-1:0] DEF_ACTIVE_CYC  = 25'd8388608;
  localparam logic [TIMER_W-1:0] DEF_RECOVER_CYC = 25'd4194304;

  typedef enum logic [3:0] {
    KIND_NONE    = 4'd0,
    KIND_SMASH_U = 4'd1,
    KIND_SMASH_D = 4'd2,
    KIND_SMASH_L = 4'd3,
    KIND_SMASH_R = 4'd4,
    KIND_JAB     = 4'd5,
    KIND_SPEC_U  = 4'd6,
    KIND_SPEC_D  = 4'd7,
    KIND_SPEC_L  = 4'd8,
    KIND_SPEC_R  = 4'd9,
    KIND_SPEC_N  = 4'd10
  } kind_e;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_WINDUP  = 2'd1,
    PH_ACTIVE  = 2'd2,
    PH_RECOVER = 2'd3
  } phase_e;

  typedef enum logic {
    OWNER_P1 = 1'b0,
    OWNER_P2 = 1'b1
  } owner_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] kind;
  } slot_t;

  function automatic logic kind_valid(input logic [3:0] k);
    return (k >= 4'(KIND_SMASH_U)) && (k <= 4'(KIND_SPEC_N));
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each attack phase; o_done flags a count of zero.
module phase_timer
  import attack_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_value,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/attack_scheduler.sv
// Round-robin arbiter and windup/active/recover sequencer for the shared attack engine.
// Define ATTACK_SCHED_QUEUE_EN to capture requests arriving while an attack is in progress.
module attack_scheduler
  import attack_pkg::*;
#(
  parameter logic [TIMER_W-1:0] WINDUP_CYC  = DEF_WINDUP_CYC,
  parameter logic [TIMER_W-1:0] ACTIVE_CYC  = DEF_ACTIVE_CYC,
  parameter logic [TIMER_W-1:0] RECOVER_CYC = DEF_RECOVER_CYC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       p1_req,
  input  logic [3:0] p1_kind,
  input  logic       p2_req,
  input  logic [3:0] p2_kind,
  input  logic       eng_hit,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic       sel,
  output logic [1:0] phase,
  output logic [3:0] eng_kind,
  output logic       eng_active,
  output logic       busy,
  output logic       hit_valid,
  output logic       hit_owner,
  output logic [3:0] hit_kind
);

  phase_e             r_state;
  phase_e             w_state_next;
  owner_e             r_last_owner;
  slot_t              r_slot1;
  slot_t              r_slot2;
  logic               r_hit_done;
  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_done;
  logic               w_cap_en;

`ifdef ATTACK_SCHED_QUEUE_EN
  assign w_cap_en = 1'b1;
`else
  assign w_cap_en = 1'b0;
`endif

  logic       w_req1_ok, w_req2_ok, w_cand1, w_cand2;
  logic       w_grant1, w_grant2, w_grant;
  logic [3:0] w_kind1, w_kind2;

  assign w_req1_ok = p1_req && kind_valid(p1_kind);
  assign w_req2_ok = p2_req && kind_valid(p2_kind);
  assign w_cand1   = r_slot1.valid || w_req1_ok;
  assign w_cand2   = r_slot2.valid || w_req2_ok;
  assign w_kind1   = r_slot1.valid ? r_slot1.kind : p1_kind;
  assign w_kind2   = r_slot2.valid ? r_slot2.kind : p2_kind;
  // On a tie the player who did not own the previous attack wins.
  assign w_grant1  = (r_state == PH_IDLE) && w_cand1 && (!w_cand2 || (r_last_owner == OWNER_P2));
  assign w_grant2  = (r_state == PH_IDLE) && w_cand2 && !w_grant1;
  assign w_grant   = w_grant1 || w_grant2;

  phase_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= PH_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    unique case (r_state)
      PH_IDLE:    if (w_grant) begin w_state_next = PH_WINDUP;  w_load = 1'b1; w_load_val = WINDUP_CYC - TIMER_W'(1);  end
      PH_WINDUP:  if (w_done)  begin w_state_next = PH_ACTIVE;  w_load = 1'b1; w_load_val = ACTIVE_CYC - TIMER_W'(1);  end
      PH_ACTIVE:  if (w_done)  begin w_state_next = PH_RECOVER; w_load = 1'b1; w_load_val = RECOVER_CYC - TIMER_W'(1); end
      PH_RECOVER: if (w_done)  w_state_next = PH_IDLE;
      default:    w_state_next = PH_IDLE;
    endcase
  end

  always_comb begin
    phase      = r_state;
    eng_active = (r_state == PH_ACTIVE);
    busy       = (r_state != PH_IDLE);
  end

  // Slots only fill in queue builds: the losing tie request or any request while busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slot1 <= '0;
      r_slot2 <= '0;
    end else begin
      if (w_grant1)                                     r_slot1.valid <= 1'b0;
      else if (w_cap_en && w_req1_ok && !r_slot1.valid) r_slot1 <= {1'b1, p1_kind};
      if (w_grant2)                                     r_slot2.valid <= 1'b0;
      else if (w_cap_en && w_req2_ok && !r_slot2.valid) r_slot2 <= {1'b1, p2_kind};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p1_ack       <= 1'b0;
      p2_ack       <= 1'b0;
      sel          <= 1'b0;
      eng_kind     <= 4'(KIND_NONE);
      r_last_owner <= OWNER_P2;
      r_hit_done   <= 1'b0;
      hit_valid    <= 1'b0;
      hit_owner    <= 1'b0;
      hit_kind     <= 4'(KIND_NONE);
    end else begin
      p1_ack    <= w_grant1;
      p2_ack    <= w_grant2;
      hit_valid <= 1'b0;
      if (w_grant) begin
        sel          <= w_grant2;
        eng_kind     <= w_grant2 ? w_kind2 : w_kind1;
        r_last_owner <= w_grant2 ? OWNER_P2 : OWNER_P1;
        r_hit_done   <= 1'b0;
      end else if ((r_state == PH_RECOVER) && w_done) begin
        eng_kind <= 4'(KIND_NONE);
      end
      if ((r_state == PH_ACTIVE) && eng_hit && !r_hit_done) begin
        r_hit_done <= 1'b1;
        hit_valid  <= 1'b1;
        hit_owner  <= sel;
        hit_kind   <= eng_kind;
      end
    end
  end

endmodule
